fadd_share_ctrl: RTL

//  Sequences one shared combinational FP adder (FADD/FSUB datapath) between two requesters (0: FP issue, 1: FP accumulate).

---
 rtl/fadd_share_ctrl_if.sv | 61 ++++++
 rtl/fadd_share_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fadd_share_ctrl_if.sv
// Bundles the requester, shared-adder and response signals of fadd_share_ctrl.
// slave = the controller; master = its environment (requesters, adder, consumer).
interface fadd_share_ctrl_if #(
  parameter int unsigned TAG_W = 4
) ();
  logic              req0_valid;
  logic              req0_ready;
  logic [31:0]       req0_a;
  logic [31:0]       req0_b;
  logic              req0_sub;
  logic [2:0]        req0_rm;
  logic [TAG_W-1:0]  req0_tag;

  logic              req1_valid;
  logic              req1_ready;
  logic [31:0]       req1_a;
  logic [31:0]       req1_b;
  logic              req1_sub;
  logic [2:0]        req1_rm;
  logic [TAG_W-1:0]  req1_tag;

  logic [31:0]       fa_a;
  logic [31:0]       fa_b;
  logic              fa_sub;
  logic [1:0]        fa_rm;
  logic [31:0]       fa_s;
  logic              fa_invalid;
  logic              fa_of;
  logic              fa_uf;
  logic              fa_nx;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_port;
  logic [TAG_W-1:0]  rsp_tag;
  logic [31:0]       rsp_result;
  logic [4:0]        rsp_flags;
  logic              rsp_illegal;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub, req0_rm, req0_tag,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sub, req1_rm, req1_tag,
    output req1_ready,
    output fa_a, fa_b, fa_sub, fa_rm,
    input  fa_s, fa_invalid, fa_of, fa_uf, fa_nx,
    output rsp_valid, rsp_port, rsp_tag, rsp_result, rsp_flags, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub, req0_rm, req0_tag,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sub, req1_rm, req1_tag,
    input  req1_ready,
    input  fa_a, fa_b, fa_sub, fa_rm,
    output fa_s, fa_invalid, fa_of, fa_uf, fa_nx,
    input  rsp_valid, rsp_port, rsp_tag, rsp_result, rsp_flags, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/fadd_share_ctrl.sv
// Shares one combinational FP adder between two requesters: round-robin grant,
// rm decode, multicycle operand hold, registered response and sticky fflags.
module fadd_share_ctrl #(
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           frm,
  input  logic                 fflags_clr,
  output logic [4:0]           fflags,
  output logic                 busy,
  fadd_share_ctrl_if.slave     bus
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic              sub_q, sub_d;
  logic [1:0]        rm_q, rm_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              port_q, port_d;
  logic              illegal_q, illegal_d;
  logic [31:0]       res_q, res_d;
  logic [4:0]        flags_q, flags_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [4:0]        fflags_q, fflags_d;
  logic              busy_q, busy_d;

  logic              gnt0_c, gnt1_c, accept_c, hs_c;
  logic [2:0]        dec_c;

  // {illegal, adder rm}; DYN resolves through frm before the legality check
  function automatic logic [2:0] decode_rm(input logic [2:0] rm, input logic [2:0] dyn);
    logic [2:0] eff;
    eff = (rm == 3'b111) ? dyn : rm;
    case (eff)
      3'b000:  decode_rm = 3'b0_00;
      3'b001:  decode_rm = 3'b0_11;
      3'b010:  decode_rm = 3'b0_01;
      3'b011:  decode_rm = 3'b0_10;
      default: decode_rm = 3'b1_00;
    endcase
  endfunction

  always_comb begin
    gnt0_c   = (state_q == S_IDLE) && !rst && bus.req0_valid && (!bus.req1_valid || last_q);
    gnt1_c   = (state_q == S_IDLE) && !rst && bus.req1_valid && (!bus.req0_valid || !last_q);
    accept_c = gnt0_c || gnt1_c;
    hs_c     = rsp_valid_q && bus.rsp_ready;
    dec_c    = decode_rm(gnt1_c ? bus.req1_rm : bus.req0_rm, frm);
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    rm_d        = rm_q;
    tag_d       = tag_q;
    port_d      = port_q;
    illegal_d   = illegal_q;
    res_d       = res_q;
    flags_d     = flags_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          a_d       = gnt1_c ? bus.req1_a   : bus.req0_a;
          b_d       = gnt1_c ? bus.req1_b   : bus.req0_b;
          sub_d     = gnt1_c ? bus.req1_sub : bus.req0_sub;
          tag_d     = gnt1_c ? bus.req1_tag : bus.req0_tag;
          port_d    = gnt1_c;
          last_d    = gnt1_c;
          illegal_d = dec_c[2];
          if (dec_c[2]) begin
            res_d   = 32'd0;
            flags_d = 5'd0;
            state_d = S_RESP;
          end else begin
            rm_d    = dec_c[1:0];
            cnt_d   = CNT_W'(EXEC_CYCLES - 1);
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == CNT_W'(0)) begin
          res_d       = bus.fa_s;
          flags_d     = {bus.fa_invalid, 1'b0, bus.fa_of, bus.fa_uf, bus.fa_nx};
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        // illegal ops arrive here with rsp_valid still low and raise it one cycle later
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    fflags_d = (fflags_clr ? 5'd0 : fflags_q) | (hs_c ? flags_q : 5'd0);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      rm_q        <= '0;
      tag_q       <= '0;
      port_q      <= 1'b0;
      illegal_q   <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
      rsp_valid_q <= 1'b0;
      fflags_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      rm_q        <= rm_d;
      tag_q       <= tag_d;
      port_q      <= port_d;
      illegal_q   <= illegal_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      rsp_valid_q <= rsp_valid_d;
      fflags_q    <= fflags_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req0_ready  = gnt0_c;
  assign bus.req1_ready  = gnt1_c;
  assign bus.fa_a        = a_q;
  assign bus.fa_b        = b_q;
  assign bus.fa_sub      = sub_q;
  assign bus.fa_rm       = rm_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_port    = port_q;
  assign bus.rsp_tag     = tag_q;
  assign bus.rsp_result  = res_q;
  assign bus.rsp_flags   = flags_q;
  assign bus.rsp_illegal = illegal_q;
  assign fflags          = fflags_q;
  assign busy            = busy_q;
endmodule
